// File: rtl/modexp_sched.sv
// modexp_sched: round-robin scheduler sharing one modular-exponentiation engine between N requesters
module modexp_sched #(
    parameter int N   = 4,
    parameter int W   = 32,
    parameter int RW  = 64,
    parameter int TMO = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*W-1:0]  base_i,
    input  logic [N*W-1:0]  exp_i,
    input  logic [N*W-1:0]  mod_i,
    output logic [N-1:0]    ack,
    output logic [N-1:0]    done,
    output logic [N-1:0]    err,
    output logic [RW-1:0]   result,
    output logic            busy,
    output logic            eng_start,
    output logic [W-1:0]    eng_base,
    output logic [W-1:0]    eng_exp,
    output logic [W-1:0]    eng_mod,
    input  logic            eng_done,
    input  logic [RW-1:0]   eng_result
);
    localparam int PW = N > 1 ? $clog2(N) : 1;
    localparam int CW = $clog2(TMO);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, RESP, DRAIN} state_t;

    state_t        state, nxt;
    logic [PW-1:0] ptr, sel, pick, idx;
    logic [CW-1:0] cnt;
    logic [N-1:0]  sel_oh;
    logic          err_q, tmo;

    assign sel_oh    = N'(1) << sel;
    assign tmo       = cnt == CW'(TMO - 1);
    assign ack       = state == LAUNCH ? sel_oh : '0;
    assign done      = state == RESP ? sel_oh : '0;
    assign err       = err_q ? sel_oh : '0;
    assign busy      = state != IDLE;
    assign eng_start = state == LAUNCH;

    // first requester at or after ptr in rotation order; scanning backwards lets the nearest win
    always_comb begin
        pick = '0;
        idx  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr) + k) % N);
            if (req[idx]) pick = idx;
        end
    end

    // next state; done beats timeout when both land in the same WAIT cycle
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = |req ? LAUNCH : IDLE;
            LAUNCH:  nxt = WAIT;
            WAIT:    nxt = eng_done ? RESP : tmo ? DRAIN : WAIT;
            RESP:    nxt = IDLE;
            DRAIN:   nxt = eng_done ? IDLE : DRAIN;
            default: nxt = IDLE;
        endcase
    end

    // state, grant pointer, watchdog, latched operands and result
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            sel      <= '0;
            cnt      <= '0;
            err_q    <= 1'b0;
            result   <= '0;
            eng_base <= '0;
            eng_exp  <= '0;
            eng_mod  <= '0;
        end else begin
            state <= nxt;
            err_q <= state == WAIT && !eng_done && tmo;
            if (state == IDLE && |req) begin
                sel      <= pick;
                ptr      <= pick == PW'(N - 1) ? '0 : pick + 1'b1;
                eng_base <= base_i[int'(pick) * W +: W];
                eng_exp  <= exp_i[int'(pick) * W +: W];
                eng_mod  <= mod_i[int'(pick) * W +: W];
            end
            if (state == LAUNCH)
                cnt <= '0;
            else if (state == WAIT && !eng_done && !tmo)
                cnt <= cnt + 1'b1;
            if (state == WAIT && eng_done)
                result <= eng_result;
        end
    end
endmodule

// File: tb/tb_modexp_sched.sv
// tb_modexp_sched: table, directed and randomized checks of modexp_sched against a cycle-level reference model
module tb_modexp_sched;
    localparam int N = 4, W = 32, RW = 64, TMO = 16;

    typedef struct {
        logic [N-1:0] rq;
        int           lat;
        logic [W-1:0] b, e, m;
        int           slot;
        int           kind;
        logic [RW-1:0] res;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [W-1:0] base_a [N], exp_a [N], mod_a [N];
    logic [N*W-1:0] base_i, exp_i, mod_i;
    logic [N-1:0] ack, done, err;
    logic [RW-1:0] result, eng_result = '0;
    logic busy, eng_start, eng_done = 1'b0;
    logic [W-1:0] eng_base, eng_exp, eng_mod;

    int n_chk = 0, n_fail = 0, cyc = 0;
    int m_free = 0, m_done = -1, m_err = -1, m_ptr = 0, m_sel = 0;
    logic [RW-1:0] m_res = '0, m_last = '0;
    logic [N-1:0] req_d = '0;
    int grants[$], ack_cyc[$], job_kind[$], job_cyc[$];
    logic [RW-1:0] job_res[$];
    int cur_lat = 1, eng_left = 0;
    bit rand_lat = 0;
    logic [RW-1:0] eng_override = '0, eng_val = '0;
    vec_t tbl [5];

    for (genvar i = 0; i < N; i++) begin : g_pack
        assign base_i[i*W +: W] = base_a[i];
        assign exp_i[i*W +: W]  = exp_a[i];
        assign mod_i[i*W +: W]  = mod_a[i];
    end

    modexp_sched #(.N(N), .W(W), .RW(RW), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .base_i(base_i), .exp_i(exp_i), .mod_i(mod_i),
        .ack(ack), .done(done), .err(err), .result(result), .busy(busy),
        .eng_start(eng_start), .eng_base(eng_base), .eng_exp(eng_exp), .eng_mod(eng_mod),
        .eng_done(eng_done), .eng_result(eng_result)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] modexp(logic [W-1:0] b, logic [W-1:0] e, logic [W-1:0] m);
        logic [63:0] r, x, mm;
        mm = 64'(m);
        r  = mm == 64'd1 ? 64'd0 : 64'd1;
        x  = 64'(b) % mm;
        for (int i = 0; i < W; i++) begin
            if (e[i]) r = (r * x) % mm;
            x = (x * x) % mm;
        end
        return r;
    endfunction

    function automatic int rr_pick(logic [N-1:0] r, int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(int s);
        logic [N-1:0] o;
        o = '0;
        if (s >= 0) o[s] = 1'b1;
        return o;
    endfunction

    // one clock: check outputs mid-cycle against the model, then drive the engine and requesters after the edge
    task automatic step();
        int s;
        logic [N-1:0] drop;
        @(negedge clk);
        s = (cyc - 1 >= m_free && req_d != 0) ? rr_pick(req_d, m_ptr) : -1;
        chk("ack", ack, onehot(s));
        chk("eng_start", eng_start, s >= 0);
        if (s >= 0) begin
            chk("eng_base", eng_base, base_a[s]);
            chk("eng_exp", eng_exp, exp_a[s]);
            chk("eng_mod", eng_mod, mod_a[s]);
            if (rand_lat) cur_lat = $urandom_range(1, TMO + 8);
            m_done = cur_lat <= TMO ? cyc + cur_lat + 1 : -1;
            m_err  = cur_lat <= TMO ? -1 : cyc + TMO + 1;
            m_free = cyc + cur_lat + (cur_lat <= TMO ? 2 : 1);
            m_res  = eng_override != 0 ? eng_override : modexp(base_a[s], exp_a[s], mod_a[s]);
            m_sel  = s;
            m_ptr  = (s + 1) % N;
            grants.push_back(s);
            ack_cyc.push_back(cyc);
            job_kind.push_back(0);
            job_cyc.push_back(-1);
            job_res.push_back('0);
        end
        if (cyc == m_done) m_last = m_res;
        chk("done", done, cyc == m_done ? onehot(m_sel) : '0);
        chk("err", err, cyc == m_err ? onehot(m_sel) : '0);
        chk("busy", busy, cyc < m_free);
        chk("result", result, m_last);
        if ((done | err) != 0 && job_kind.size() > 0) begin
            job_kind[job_kind.size() - 1] = done != 0 ? 1 : 2;
            job_cyc[job_cyc.size() - 1]   = cyc;
            job_res[job_res.size() - 1]   = result;
        end
        if (eng_start) begin
            eng_left = cur_lat;
            eng_val  = eng_override != 0 ? eng_override : modexp(eng_base, eng_exp, eng_mod);
        end
        drop = ack;
        if (rst) begin
            m_free = cyc + 1;
            m_done = -1;
            m_err  = -1;
            m_ptr  = 0;
            m_last = '0;
            eng_left = 0;
        end
        req_d = req;
        @(posedge clk);
        #1;
        cyc++;
        req = req & ~drop;
        eng_done = 1'b0;
        eng_result = 64'hBAD0_BAD0_BAD0_BAD0;
        if (eng_left > 0) begin
            eng_left--;
            if (eng_left == 0) begin
                eng_done = 1'b1;
                eng_result = eng_val;
            end
        end
    endtask

    task automatic do_reset(int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
    endtask

    task automatic wait_grants(int n, int budget);
        int k = 0;
        while (grants.size() < n && k < budget) begin
            step();
            k++;
        end
        chk("grant_wait", grants.size() >= n, 1);
    endtask

    task automatic wait_quiet(int budget);
        int k = 0;
        while ((busy || req != 0) && k < budget) begin
            step();
            k++;
        end
        chk("quiet_wait", busy || req != 0, 0);
    endtask

    task automatic set_ops(int s, logic [W-1:0] b, logic [W-1:0] e, logic [W-1:0] m);
        base_a[s] = b;
        exp_a[s]  = e;
        mod_a[s]  = m;
    endtask

    initial begin
        int g, c0;
        int ord [6];
        tbl = '{
            '{4'b0001, 5,  32'd5,  32'd3,  32'd23,   0, 1, 64'd10},
            '{4'b0101, 3,  32'd2,  32'd10, 32'd1000, 2, 1, 64'd24},
            '{4'b1000, 16, 32'd3,  32'd4,  32'd7,    3, 1, 64'd4},
            '{4'b0010, 17, 32'd7,  32'd2,  32'd10,   1, 2, 64'd4},
            '{4'b1111, 1,  32'd10, 32'd2,  32'd11,   2, 1, 64'd1}
        };
        ord = '{0, 1, 2, 3, 0, 3};
        for (int i = 0; i < N; i++) set_ops(i, 32'd2, 32'd5, 32'd13);
        do_reset(3);

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < N; i++)
                if (tbl[v].rq[i]) set_ops(i, tbl[v].b, tbl[v].e, tbl[v].m);
            cur_lat = tbl[v].lat;
            g  = grants.size();
            c0 = cyc;
            req = tbl[v].rq;
            wait_quiet(300);
            chk("tbl_slot", grants.size() > g ? grants[g] : -1, tbl[v].slot);
            chk("tbl_kind", grants.size() > g ? job_kind[g] : -1, tbl[v].kind);
            chk("tbl_res", grants.size() > g ? job_res[g] : '1, tbl[v].res);
            if (v == 0) begin
                chk("ack_latency", grants.size() > g ? ack_cyc[g] - c0 : -1, 1);
                chk("done_latency", grants.size() > g ? job_cyc[g] - c0 : -1, 7);
            end
        end

        for (int i = 0; i < N; i++) set_ops(i, 32'd2, 32'd5, 32'd13);
        req = 4'b1111;
        cur_lat = 2;
        do_reset(2);
        g = grants.size();
        wait_grants(g + 4, 200);
        req = req | 4'b1001;
        wait_quiet(200);
        for (int i = 0; i < 6; i++)
            chk("fair_order", grants.size() > g + i ? grants[g + i] : -1, ord[i]);

        set_ops(0, 32'd3, 32'd3, 32'd100);
        cur_lat = 25;
        eng_override = 64'd77;
        g = grants.size();
        req = 4'b0001;
        wait_grants(g + 1, 50);
        eng_override = '0;
        cur_lat = 3;
        set_ops(2, 32'd2, 32'd3, 32'd100);
        req = 4'b0100;
        wait_grants(g + 2, 100);
        chk("tmo_result_kept", result, 64'd6);
        chk("tmo_kind", job_kind.size() > g ? job_kind[g] : -1, 2);
        chk("tmo_err_gap", job_cyc.size() > g ? job_cyc[g] - ack_cyc[g] : -1, TMO + 1);
        chk("tmo_requeue_gap", ack_cyc.size() > g + 1 ? ack_cyc[g + 1] - ack_cyc[g] : -1, 27);
        wait_quiet(100);
        chk("tmo_next_res", job_res.size() > g + 1 ? job_res[g + 1] : '1, 64'd8);

        set_ops(1, 32'd4, 32'd4, 32'd9);
        cur_lat = 10;
        g = grants.size();
        req = 4'b0010;
        wait_grants(g + 1, 50);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_eng_base", eng_base, 0);
        chk("rst_eng_exp", eng_exp, 0);
        chk("rst_eng_mod", eng_mod, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        set_ops(1, 32'd3, 32'd2, 32'd5);
        set_ops(2, 32'd3, 32'd3, 32'd5);
        cur_lat = 2;
        g = grants.size();
        req = 4'b0110;
        wait_quiet(100);
        chk("rst_first", grants.size() > g ? grants[g] : -1, 1);
        chk("rst_second", grants.size() > g + 1 ? grants[g + 1] : -1, 2);

        set_ops(0, 32'd5, 32'd3, 32'd23);
        cur_lat = 6;
        g = grants.size();
        req = 4'b0001;
        wait_grants(g + 1, 50);
        base_a[0] = 32'd9;
        repeat (4) begin
            step();
            chk("iso_eng_base", eng_base, 32'd5);
        end
        wait_quiet(100);
        chk("iso_eng_base_end", eng_base, 32'd5);
        chk("iso_res", job_res.size() > g ? job_res[g] : '1, 64'd10);

        rand_lat = 1;
        for (int t = 0; t < 4000; t++) begin
            rst = $urandom_range(0, 999) == 0;
            for (int i = 0; i < N; i++)
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    set_ops(i, $urandom, $urandom, W'($urandom_range(1, 65535)));
                    req[i] = 1'b1;
                end
            step();
        end
        rst = 1'b0;
        rand_lat = 0;
        cur_lat = 1;
        wait_quiet(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
